// File: rtl/toycpu_pkg.sv
// Shared definitions for the toy CPU data-RAM arbiter: default widths,
// requester (owner) encoding and the arbiter FSM state type.
package toycpu_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCK_B = 1'b1
  } state_e;

endpackage

// File: rtl/toycpu_rr_arb2.sv
// Combinational two-way round-robin pick. When both requesters are active,
// the one that did not win most recently (`last`) is chosen.
module toycpu_rr_arb2
  import toycpu_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic pick_a,
  output logic pick_b
);

  // A wins when alone, or when both ask and B was the previous winner.
  always_comb begin
    pick_a = req_a & (~req_b | (last == OWNER_B));
    pick_b = req_b & ~pick_a;
  end

endmodule

// File: rtl/toycpu_mem_arbiter.sv
// Shares a single-port synchronous data RAM between the CPU data port (A)
// and a debug/loader DMA port (B). Grants are combinational in the accepting
// cycle; B may take a bounded exclusive lock; read data is steered back to
// the requester that issued the read one cycle after its grant.
module toycpu_mem_arbiter
  import toycpu_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_lock,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_rd_q, a_rd_d;
  logic             b_rd_q, b_rd_d;
  logic             pick_a, pick_b;

  toycpu_rr_arb2 u_rr (
    .req_a  (a_req),
    .req_b  (b_req),
    .last   (last_q),
    .pick_a (pick_a),
    .pick_b (pick_b)
  );

  // Grants: round-robin in ARB, B-only while locked; nothing while in reset.
  always_comb begin
    a_gnt   = rst & (state_q == ARB) & pick_a;
    b_gnt   = rst & ((state_q == ARB) ? pick_b : b_req);
    a_stall = a_req & ~a_gnt;
  end

  // RAM port is driven from whichever requester won this cycle.
  always_comb begin
    mem_en    = a_gnt | b_gnt;
    mem_we    = a_gnt ? a_we : (b_gnt & b_we);
    mem_addr  = a_gnt ? a_addr : b_addr;
    mem_wdata = a_gnt ? a_wdata : b_wdata;
  end

  // Read return: the tag registered at grant time selects the destination;
  // rdata is forced to zero whenever the matching rvalid is low.
  always_comb begin
    a_rvalid = rst & a_rd_q;
    b_rvalid = rst & b_rd_q;
    a_rdata  = a_rvalid ? mem_rdata : '0;
    b_rdata  = b_rvalid ? mem_rdata : '0;
  end

  // Next-state logic for the lock FSM, round-robin history and burst counter.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    a_rd_d  = a_gnt & ~a_we;
    b_rd_d  = b_gnt & ~b_we;
    case (state_q)
      ARB: begin
        if (a_gnt) begin
          last_d = OWNER_A;
        end else if (b_gnt) begin
          last_d = OWNER_B;
          // The granting cycle is the first locked beat, so a one-beat
          // burst never needs the LOCK_B state at all.
          if (b_lock && (MAX_BURST > 1)) begin
            state_d = LOCK_B;
            cnt_d   = CNT_ONE;
          end
        end
      end
      LOCK_B: begin
        last_d = OWNER_B;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        // Leaving with last=B hands the next contested cycle to A.
        if (!b_lock || (cnt_d == CNT_MAX)) begin
          state_d = ARB;
          cnt_d   = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // State registers; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB;
      last_q  <= OWNER_B;
      cnt_q   <= '0;
      a_rd_q  <= 1'b0;
      b_rd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_rd_q  <= a_rd_d;
      b_rd_q  <= b_rd_d;
    end
  end

endmodule

// File: tb/tb_toycpu_mem_arbiter.sv
// Directed bench for toycpu_mem_arbiter with a behavioural RAM, a shadow
// memory for expected data and a read-return scoreboard.
module tb_toycpu_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_stall, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_lock, b_we;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram     [0:255];
  logic [DW-1:0] exp_mem [0:255];

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rd_t;
  rd_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  toycpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_stall   (a_stall),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_lock    (b_lock),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port synchronous RAM: read data appears the cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Checks one cycle (inputs already applied), then advances to the next
  // cycle's drive point (1 time unit after the rising edge).
  task automatic cyc(input logic ea, input logic eb, input string tag);
    rd_t e;
    #1;
    if (!rst) sb.delete();
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ":a_rvalid"}, 32'(a_rvalid), 32'(e.port == 1'b0));
      chk({tag, ":b_rvalid"}, 32'(b_rvalid), 32'(e.port == 1'b1));
      if (e.port == 1'b0) begin
        chk({tag, ":a_rdata"}, 32'(a_rdata), 32'(e.data));
        chk({tag, ":b_rdata0"}, 32'(b_rdata), 32'h0);
      end else begin
        chk({tag, ":b_rdata"}, 32'(b_rdata), 32'(e.data));
        chk({tag, ":a_rdata0"}, 32'(a_rdata), 32'h0);
      end
    end else begin
      chk({tag, ":a_rvalid0"}, 32'(a_rvalid), 32'h0);
      chk({tag, ":b_rvalid0"}, 32'(b_rvalid), 32'h0);
      chk({tag, ":a_rdata0"}, 32'(a_rdata), 32'h0);
      chk({tag, ":b_rdata0"}, 32'(b_rdata), 32'h0);
    end
    chk({tag, ":a_gnt"}, 32'(a_gnt), 32'(ea));
    chk({tag, ":b_gnt"}, 32'(b_gnt), 32'(eb));
    chk({tag, ":a_stall"}, 32'(a_stall), 32'(a_req & ~ea));
    chk({tag, ":mem_en"}, 32'(mem_en), 32'(ea | eb));
    if (ea) begin
      chk({tag, ":mem_addrA"}, 32'(mem_addr), 32'(a_addr));
      chk({tag, ":mem_weA"}, 32'(mem_we), 32'(a_we));
      if (a_we) exp_mem[a_addr[7:0]] = a_wdata;
      else      sb.push_back('{1'b0, exp_mem[a_addr[7:0]]});
    end else if (eb) begin
      chk({tag, ":mem_addrB"}, 32'(mem_addr), 32'(b_addr));
      chk({tag, ":mem_weB"}, 32'(mem_we), 32'(b_we));
      if (b_we) begin
        chk({tag, ":mem_wdataB"}, 32'(mem_wdata), 32'(b_wdata));
        exp_mem[b_addr[7:0]] = b_wdata;
      end else begin
        sb.push_back('{1'b1, exp_mem[b_addr[7:0]]});
      end
    end else begin
      chk({tag, ":mem_we0"}, 32'(mem_we), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'hA500 ^ 16'(i);
      exp_mem[i] = 16'hA500 ^ 16'(i);
    end
    ram[8'h80]     = 16'h0081;
    exp_mem[8'h80] = 16'h0081;

    // Reset with both requesting reads
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0020; a_wdata = '0;
    b_req = 1'b1; b_lock = 1'b0; b_we = 1'b0; b_addr = 16'h0030; b_wdata = '0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, "rst0");
    cyc(1'b0, 1'b0, "rst1");
    rst = 1'b1;
    cyc(1'b1, 1'b0, "rel");

    // A-only read of 0x0080
    b_req = 1'b0; a_addr = 16'h0080;
    cyc(1'b1, 1'b0, "a_rd80");

    // B-only read so that A is favoured next
    a_req = 1'b0; b_req = 1'b1; b_addr = 16'h0040;
    cyc(1'b0, 1'b1, "b_rd40");

    // Both continuously reading: A,B,A,B
    a_req = 1'b1; a_addr = 16'h0020; b_addr = 16'h0030;
    cyc(1'b1, 1'b0, "rr0");
    cyc(1'b0, 1'b1, "rr1");
    cyc(1'b1, 1'b0, "rr2");
    cyc(1'b0, 1'b1, "rr3");

    // A alone so B wins the following contested cycle
    b_req = 1'b0; a_addr = 16'h0050;
    cyc(1'b1, 1'b0, "a_rd50");

    // Locked B burst of MAX_BURST writes while A waits
    a_addr = 16'h0060;
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b1;
    b_addr = 16'h0010; b_wdata = 16'h1111;
    cyc(1'b0, 1'b1, "lk0");
    for (int k = 1; k < 4; k++) begin
      b_addr  = 16'h0010 + 16'(k);
      b_wdata = 16'h1111 * 16'(k + 1);
      cyc(1'b0, 1'b1, $sformatf("lk%0d", k));
    end
    b_lock = 1'b0; b_we = 1'b0; b_addr = 16'h0010;
    cyc(1'b1, 1'b0, "lk_a");

    // Readback of the burst through B
    a_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_addr = 16'h0010 + 16'(k);
      cyc(1'b0, 1'b1, $sformatf("rb%0d", k));
    end

    // Lock dropped after two beats
    b_req = 1'b0;
    a_req = 1'b1; a_addr = 16'h0070;
    cyc(1'b1, 1'b0, "a_rd70");
    a_addr = 16'h0014;
    b_req = 1'b1; b_lock = 1'b1; b_we = 1'b1;
    b_addr = 16'h0014; b_wdata = 16'h5555;
    cyc(1'b0, 1'b1, "ld0");
    b_addr = 16'h0015; b_wdata = 16'h6666;
    cyc(1'b0, 1'b1, "ld1");
    b_req = 1'b0; b_lock = 1'b0; b_we = 1'b0;
    cyc(1'b0, 1'b0, "ld_drop");
    cyc(1'b1, 1'b0, "ld_a");

    // Reset while an A read is in flight
    a_addr = 16'h0015;
    cyc(1'b1, 1'b0, "mr_gnt");
    rst = 1'b0; b_req = 1'b1; b_addr = 16'h0030;
    cyc(1'b0, 1'b0, "mr_rst0");
    cyc(1'b0, 1'b0, "mr_rst1");
    rst = 1'b1;
    cyc(1'b1, 1'b0, "mr_rel");
    a_req = 1'b0; b_req = 1'b0;
    cyc(1'b0, 1'b0, "end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/toycpu_mem_arbiter.md
Name: toycpu_mem_arbiter

Overview:
Shares the single-port synchronous data RAM between two requesters: the toy CPU data port (A) and a debug/loader DMA port (B).
- Arbitrates per cycle, round-robin.
- Supports a bounded locked burst for B, so programs and test vectors can be loaded while the CPU runs.
- Routes read data back to the requester that issued the read.
- Provides a stall indication for the CPU.

Parameters:
ADDR_W, 16, address width of RAM and both ports
DATA_W, 16, data width
MAX_BURST, 4, max cycles B may hold a lock (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low
a_req  in  1  CPU access request
a_we  in  1  CPU write enable (1=write, 0=read)
a_addr  in  ADDR_W  CPU address
a_wdata  in  DATA_W  CPU write data
a_gnt  out  1  CPU request accepted this cycle
a_stall  out  1  a_req & ~a_gnt
a_rvalid  out  1  CPU read data valid
a_rdata  out  DATA_W  CPU read data
b_req  in  1  DMA access request
b_lock  in  1  DMA requests exclusive ownership
b_we  in  1  DMA write enable
b_addr  in  ADDR_W  DMA address
b_wdata  in  DATA_W  DMA write data
b_gnt  out  1  DMA request accepted this cycle
b_rvalid  out  1  DMA read data valid
b_rdata  out  DATA_W  DMA read data
mem_en  out  1  RAM access strobe
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en & ~mem_we

Behaviour:
Reset (rst=0 at clk edge):
- state=ARB, last=B, cnt=0, read tags cleared.
- All gnt, rvalid and mem_en outputs are 0; rdata outputs are 0.
- A reset during a pending read discards it: no rvalid follows.

Grant timing:
- Grants are combinational in the accepting cycle.
- mem_* is driven from the winner in that same cycle; at most one gnt per cycle.
- mem_en = a_gnt | b_gnt. With no grant, mem_we=0 and addr/wdata are don't-care.

Requester rules:
- Hold req/we/addr/wdata stable until gnt.
- req may drop in the cycle after gnt; a back-to-back request is allowed.

Read return:
- Read granted in cycle N: x_rvalid=1 in cycle N+1 with x_rdata=mem_rdata.
- rdata is 0 when rvalid=0.
- Writes never produce rvalid.

State ARB:
- Only one requester active: it wins.
- Both active: the requester not equal to `last` wins.
- `last` updates to the winner on every grant.
- B granted with b_lock=1: go to LOCK_B, cnt=1.

State LOCK_B:
- A is never granted.
- B is granted whenever b_req=1.
- cnt increments every cycle spent in LOCK_B, idle or not.
- Exit to ARB at the edge where b_lock=0 or cnt==MAX_BURST. On exit, last=B, so a waiting A wins the next cycle.
- Worst-case A wait after B takes the lock is MAX_BURST cycles.

Simultaneous events:
- b_lock asserted in ARB on a cycle B loses arbitration: no lock is taken.
- b_lock is evaluated only with a B grant.

Widths:
- cnt is $clog2(MAX_BURST+1) bits and saturates; it never wraps.

Decomposition:
- Package toycpu_pkg:
  - ADDR_W/DATA_W defaults
  - owner encoding OWNER_A=1'b0, OWNER_B=1'b1
  - state enum {ARB, LOCK_B}
- Natural sub-module toycpu_rr_arb2:
  - combinational 2-way round-robin pick from (req_a, req_b, last)
  - the FSM, burst counter and read-tag pipeline stay in the top.

Test Plan:
1. rst=0 for 2 cycles with a_req=b_req=1 -> a_gnt=b_gnt=mem_en=a_rvalid=b_rvalid=0. First cycle after release -> a_gnt=1.
2. A-only read of 0x0080, RAM holds 0x0081 -> a_gnt=1, mem_addr=0x0080 same cycle. Next cycle a_rvalid=1, a_rdata=0x0081. a_stall=0 throughout.
3. a_req=b_req=1 continuous, b_lock=0, all reads -> grants A,B,A,B over 4 cycles. a_stall=1 exactly in B cycles. Each rvalid lands on the correct port one cycle later.
4. MAX_BURST=4, b_lock=1, B writes 0x1111..0x4444 to 0x0010..0x0013, a_req=1 held -> b_gnt 4 consecutive cycles, a_stall=1 for those 4, a_gnt=1 in cycle 5. Readback of 0x0010..0x0013 matches.
5. B locked burst with b_lock dropped after 2 beats, a_req=1 -> a_gnt=1 in the cycle after b_lock falls.
6. Reset mid-read: A read granted cycle N, rst=0 at edge N+1 -> a_rvalid stays 0. After release, A is granted first.
